// File: rtl/mage_onehot_accum_if.sv
// Handshake/bus bundle for mage_onehot_accum: index stream in, completed mask out.
// Signal suffixes are named from the accumulator's point of view.
interface mage_onehot_accum_if #(
   parameter int LEN = 32
);
   localparam int IDXW = $clog2(LEN);
   localparam int CNTW = $clog2(LEN + 1);

   logic            idx_valid_i;
   logic            idx_ready_o;
   logic [IDXW-1:0] idx_i;
   logic            idx_last_i;
   logic            mask_valid_o;
   logic            mask_ready_i;
   logic [LEN-1:0]  mask_o;
   logic [CNTW-1:0] count_o;
   logic            empty_o;
   logic            oor_o;
   logic            dup_o;

   modport slave (
      input  idx_valid_i, idx_i, idx_last_i, mask_ready_i,
      output idx_ready_o, mask_valid_o, mask_o, count_o, empty_o, oor_o, dup_o
   );

   modport master (
      output idx_valid_i, idx_i, idx_last_i, mask_ready_i,
      input  idx_ready_o, mask_valid_o, mask_o, count_o, empty_o, oor_o, dup_o
   );
endinterface

// File: rtl/mage_onehot_accum.sv
// Index-to-mask accumulator: ORs one-hot decoded indices into a LEN-bit mask per frame.
// Optional duplicate-index detection is built when MAGE_ONEHOT_ACCUM_DUP_DETECT_EN is defined.
module mage_onehot_accum #(
   parameter int LEN = 32
) (
   input logic                  clk_i,
   input logic                  rst_i,
   input logic                  clear_i,
   mage_onehot_accum_if.slave   bus
);
   localparam int CNTW = $clog2(LEN + 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t          state_q, state_d;
   logic [LEN-1:0]  mask_q, mask_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            oor_q, oor_d;
   logic [LEN-1:0]  onehot;
   logic            hit;
   logic            idx_fire;
   logic            mask_fire;

   // An index >= LEN shifts the single one out of range, so onehot == 0 flags it.
   assign onehot    = {{(LEN-1){1'b0}}, 1'b1} << bus.idx_i;
   assign hit       = |(mask_q & onehot);
   assign idx_fire  = (state_q == ACCUM) & bus.idx_valid_i;
   assign mask_fire = (state_q == HOLD) & bus.mask_ready_i;

`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
   logic dup_q, dup_d;
`endif

   // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      count_d = count_q;
      oor_d   = oor_q;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
      dup_d   = dup_q;
`endif
      if (idx_fire) begin
         if (onehot == '0) begin
            oor_d = 1'b1;
         end else if (!hit) begin
            mask_d  = mask_q | onehot;
            count_d = count_q + CNTW'(1);
         end
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
         else begin
            dup_d = 1'b1;
         end
`endif
         if (bus.idx_last_i) state_d = HOLD;
      end
      // Abort and mask handoff both return to an empty frame; clear also drops a same-cycle beat.
      if (clear_i || mask_fire) begin
         state_d = ACCUM;
         mask_d  = '0;
         count_d = '0;
         oor_d   = 1'b0;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
         dup_d   = 1'b0;
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         mask_q  <= '0;
         count_q <= '0;
         oor_q   <= 1'b0;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
         dup_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         count_q <= count_d;
         oor_q   <= oor_d;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
         dup_q   <= dup_d;
`endif
      end
   end

   assign bus.idx_ready_o  = (state_q == ACCUM);
   assign bus.mask_valid_o = (state_q == HOLD);
   assign bus.mask_o       = mask_q;
   assign bus.count_o      = count_q;
   assign bus.empty_o      = ~|mask_q;
   assign bus.oor_o        = oor_q;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
   assign bus.dup_o        = dup_q;
`else
   assign bus.dup_o        = 1'b0;
`endif
endmodule

// File: tb/tb_mage_onehot_accum.sv
// Bench for mage_onehot_accum: LEN=32 and LEN=20 instances share one stimulus stream
// and are compared every cycle against a frame-list model, plus literal spot values.
module tb_mage_onehot_accum;
`ifdef MAGE_ONEHOT_ACCUM_DUP_DETECT_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, clear, idx_valid, idx_last, mask_ready;
   logic [4:0] idx;
   int         checks = 0;
   int         failures = 0;
   bit         started = 1'b0;

   int         frame_q[$];
   bit         in_hold;

   always #5 clk = ~clk;

   mage_onehot_accum_if #(.LEN(32)) b32 ();
   mage_onehot_accum_if #(.LEN(20)) b20 ();

   assign b32.idx_valid_i  = idx_valid;
   assign b32.idx_i        = idx;
   assign b32.idx_last_i   = idx_last;
   assign b32.mask_ready_i = mask_ready;
   assign b20.idx_valid_i  = idx_valid;
   assign b20.idx_i        = idx;
   assign b20.idx_last_i   = idx_last;
   assign b20.mask_ready_i = mask_ready;

   mage_onehot_accum #(.LEN(32)) u32 (.clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(b32));
   mage_onehot_accum #(.LEN(20)) u20 (.clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(b20));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs from the list of indices accepted in the current frame.
   function automatic void model_out(input int q[$], input int len, output logic [31:0] m,
                                     output int cnt, output bit oor, output bit dup);
      m = '0; oor = 1'b0; dup = 1'b0;
      foreach (q[k]) begin
         if (q[k] >= len)  oor = 1'b1;
         else if (m[q[k]]) dup = 1'b1;
         else              m[q[k]] = 1'b1;
      end
      cnt = $countones(m);
      dup = dup & DUP_EN;
   endfunction

   always @(posedge clk) begin
      if (rst || clear || (in_hold && mask_ready)) begin
         frame_q.delete();
         in_hold = 1'b0;
      end else if (!in_hold && idx_valid) begin
         frame_q.push_back(int'(idx));
         if (idx_last) in_hold = 1'b1;
      end
   end

   always @(negedge clk) begin
      logic [31:0] m;
      int          c;
      bit          o, d;
      if (started) begin
         model_out(frame_q, 32, m, c, o, d);
         check("l32_ready", 64'(b32.idx_ready_o), 64'(!in_hold));
         check("l32_valid", 64'(b32.mask_valid_o), 64'(in_hold));
         check("l32_mask", 64'(b32.mask_o), 64'(m));
         check("l32_count", 64'(b32.count_o), 64'(c));
         check("l32_empty", 64'(b32.empty_o), 64'(m == 0));
         check("l32_oor", 64'(b32.oor_o), 64'(o));
         check("l32_dup", 64'(b32.dup_o), 64'(d));
         model_out(frame_q, 20, m, c, o, d);
         check("l20_ready", 64'(b20.idx_ready_o), 64'(!in_hold));
         check("l20_valid", 64'(b20.mask_valid_o), 64'(in_hold));
         check("l20_mask", 64'(b20.mask_o), 64'(m));
         check("l20_count", 64'(b20.count_o), 64'(c));
         check("l20_empty", 64'(b20.empty_o), 64'(m == 0));
         check("l20_oor", 64'(b20.oor_o), 64'(o));
         check("l20_dup", 64'(b20.dup_o), 64'(d));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input bit last);
      idx_valid = 1'b1;
      idx       = 5'(i);
      idx_last  = last;
      tick();
      idx_valid = 1'b0;
      idx_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; idx_valid = 1'b0; idx_last = 1'b0; idx = '0; mask_ready = 1'b0;
      @(posedge clk);
      started = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_ready", 64'(b32.idx_ready_o), 64'd1);
      check("rst_valid", 64'(b32.mask_valid_o), 64'd0);
      check("rst_mask", 64'(b32.mask_o), 64'd0);
      check("rst_empty", 64'(b32.empty_o), 64'd1);

      mask_ready = 1'b1;
      send(3, 0); send(0, 0); send(31, 1);
      check("f1_valid", 64'(b32.mask_valid_o), 64'd1);
      check("f1_mask", 64'(b32.mask_o), 64'h8000_0009);
      check("f1_count", 64'(b32.count_o), 64'd3);
      check("f1_empty", 64'(b32.empty_o), 64'd0);
      check("f1_oor32", 64'(b32.oor_o), 64'd0);
      check("f1_mask20", 64'(b20.mask_o), 64'h9);
      check("f1_oor20", 64'(b20.oor_o), 64'd1);
      tick();
      check("f1_ready_after", 64'(b32.idx_ready_o), 64'd1);
      check("f1_mask_after", 64'(b32.mask_o), 64'd0);

      send(5, 0); send(5, 0); send(7, 1);
      check("f2_mask", 64'(b32.mask_o), 64'hA0);
      check("f2_count", 64'(b32.count_o), 64'd2);
      check("f2_dup", 64'(b32.dup_o), 64'(DUP_EN));
      tick();

      send(19, 0); send(25, 1);
      check("f3_mask20", 64'(b20.mask_o), 64'h8_0000);
      check("f3_count20", 64'(b20.count_o), 64'd1);
      check("f3_oor20", 64'(b20.oor_o), 64'd1);
      tick();
      send(22, 1);
      check("f4_mask20", 64'(b20.mask_o), 64'd0);
      check("f4_empty20", 64'(b20.empty_o), 64'd1);
      check("f4_count20", 64'(b20.count_o), 64'd0);
      tick();

      mask_ready = 1'b0;
      send(1, 1);
      for (int k = 0; k < 4; k++) begin
         idx_valid = 1'b1; idx = 5'd9; idx_last = 1'b1;
         tick();
         check("bp_valid", 64'(b32.mask_valid_o), 64'd1);
         check("bp_ready", 64'(b32.idx_ready_o), 64'd0);
         check("bp_mask", 64'(b32.mask_o), 64'h2);
      end
      idx_valid = 1'b0; idx_last = 1'b0; mask_ready = 1'b1;
      tick();
      check("bp_done_ready", 64'(b32.idx_ready_o), 64'd1);
      check("bp_done_mask", 64'(b32.mask_o), 64'd0);

      send(2, 0); send(4, 0);
      clear = 1'b1; idx_valid = 1'b1; idx = 5'd6;
      tick();
      clear = 1'b0; idx_valid = 1'b0;
      check("clr_mask", 64'(b32.mask_o), 64'd0);
      check("clr_count", 64'(b32.count_o), 64'd0);
      check("clr_ready", 64'(b32.idx_ready_o), 64'd1);
      send(8, 1);
      check("clr_next_mask", 64'(b32.mask_o), 64'h100);
      tick();

      mask_ready = 1'b0;
      send(3, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rsth_valid", 64'(b32.mask_valid_o), 64'd0);
      check("rsth_ready", 64'(b32.idx_ready_o), 64'd1);
      check("rsth_mask", 64'(b32.mask_o), 64'd0);
      check("rsth_empty", 64'(b32.empty_o), 64'd1);

      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         clear      = ($urandom_range(0, 39) == 0);
         idx_valid  = ($urandom_range(0, 9) < 7);
         idx        = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         idx_last   = ($urandom_range(0, 5) == 0);
         mask_ready = ($urandom_range(0, 9) < 6);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mage_onehot_accum.md
# mage_onehot_accum

Index-to-mask accumulator for the Mage PE divider/normalisation path. It performs the inverse of the find-first-one encoder. It accepts a stream of bit indices over a valid/ready handshake, decodes each index to one-hot, and ORs it into a LEN-bit mask register. On the frame's last beat it presents the completed mask, with its population count, on a second valid/ready port. It sits upstream of the FU operand muxes and rebuilds lane/bit masks from index streams produced by the encoder side.

## Interface
Parameters:
- LEN, 32, mask width in bits; any value ≥ 2, power of two not required
- IDXW, $clog2(LEN), index width (derived; do not override)
- CNTW, $clog2(LEN+1), popcount width (derived)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous abort; discards the frame in progress or the held mask
- idx_valid_i  in  1  index beat valid
- idx_ready_o  out  1  accumulator can accept a beat
- idx_i  in  IDXW  bit index to set
- idx_last_i  in  1  final beat of frame
- mask_valid_o  out  1  completed mask available
- mask_ready_i  in  1  consumer accepts mask
- mask_o  out  LEN  accumulated mask
- count_o  out  CNTW  number of ones in mask_o
- empty_o  out  1  mask_o == 0 (mirrors the encoder's no-ones flag)
- oor_o  out  1  at least one index ≥ LEN was received in this frame
- dup_o  out  1  at least one index was received twice in this frame (see Configuration)

## Operation
- Two-state FSM: ACCUM and HOLD.
- **ACCUM**
  - idx_ready_o=1, mask_valid_o=0.
  - Beat accepted when idx_valid_i & idx_ready_o.
  - If idx_i < LEN and bit idx_i is clear: set the bit and increment count.
  - If idx_i < LEN and bit idx_i is already set: mask and count unchanged; sticky dup flag set.
  - If idx_i ≥ LEN: mask and count unchanged; sticky oor flag set.
  - Accepted beat with idx_last_i=1 → HOLD. The mask update from that beat is included.
- **HOLD**
  - idx_ready_o=0, mask_valid_o=1.
  - mask_o, count_o, empty_o, oor_o and dup_o are stable until the handshake.
  - On mask_valid_o & mask_ready_i: mask, count and flags clear to 0; next state ACCUM.
- mask_o, count_o and flags are visible during ACCUM (the partial frame), but are only qualified by mask_valid_o.
- count_o never exceeds LEN. Each bit is counted once.
- empty_o is combinational: ~|mask_o.
- Priority, highest first: rst_i, then clear_i, then handshakes.
  - clear_i forces ACCUM and zeroes mask, count and flags.
  - A beat presented in the same cycle as clear_i is dropped, even though idx_ready_o is high.
  - A mask handshake in the same cycle as clear_i completes for the consumer, which sampled mask_o. Internal state still ends cleared.
- No new beat is accepted in the HOLD→ACCUM transition cycle, because idx_ready_o is 0 in HOLD. This costs one bubble per frame.

## Timing
- Reset values: state ACCUM, mask_o=0, count_o=0, oor_o=0, dup_o=0, mask_valid_o=0, idx_ready_o=1, empty_o=1.
- Latency: mask_valid_o rises the cycle after the last beat is accepted.
- Throughput: one index per cycle within a frame. A frame of N beats occupies N+1 cycles minimum (N accept cycles plus 1 HOLD cycle with mask_ready_i=1).
- idx_ready_o and mask_valid_o are decoded from registered state only. There is no combinational path from idx_valid_i or mask_ready_i to either of them.
- mask_o, count_o, oor_o and dup_o are registered outputs.

## Configuration
- Macro: MAGE_ONEHOT_ACCUM_DUP_DETECT_EN.
- Defined:
  - dup flag register and the set-bit compare are built.
  - dup_o behaves as described in Operation.
- Undefined:
  - dup_o is tied to 0 and no dup logic is generated.
  - Duplicate indices remain harmless: the mask is idempotent and count does not double-increment.

## Test plan
- Reset then frame {3, 0, 31 (last)}, LEN=32, mask_ready_i=1 → mask_valid_o high one cycle after beat 3; mask_o=0x8000_0009, count_o=3, empty_o=0, oor_o=0, dup_o=0; idx_ready_o=1 on the following cycle.
- Frame {5, 5, 7 (last)} with macro defined → mask_o=0xA0, count_o=2, dup_o=1. Same frame with macro undefined → dup_o=0, mask and count unchanged.
- LEN=20, frame {19, 25 (last)} → mask_o=0x8_0000, count_o=1, oor_o=1. Frame {22 (last)} → mask_o=0, empty_o=1, count_o=0.
- Backpressure: frame {1 (last)}, hold mask_ready_i=0 for 4 cycles → mask_valid_o stays 1, idx_ready_o stays 0, mask_o=0x2 stable; beats offered in that window are not accepted; handshake on cycle 5 → ACCUM with mask_o=0.
- clear_i mid-frame after beats {2, 4}, asserted together with idx_valid_i and idx 6 → next cycle mask_o=0, count_o=0, flags 0, state ACCUM; beat 6 is not absorbed.
- rst_i asserted while in HOLD with mask_ready_i=0 → next cycle all outputs at reset values and mask_valid_o=0.
